rns_compare_const_mrc: RTL and testbench

RNS_COMPARE_CONST_MRC -- requirements
Module: rns_compare_const_mrc

---
 rtl/rns_pkg.sv | 43 ++++
 rtl/rns_mrc_digit.sv | 29 ++
 rtl/rns_compare_const_mrc.sv | 151 +++++++++++++++
 tb/tb_rns_compare_const_mrc.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rns_pkg.sv
// Shared constants and helpers for the RNS comparator: width, gcd and
// modular-inverse constant functions, plus the controller state encoding.
package rns_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MRC1 = 2'd1,
        MRC2 = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int gcd(input int a, input int b);
        int x;
        int y;
        int t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Brute-force search is fine: only ever evaluated at elaboration.
    function automatic int mod_inv(input int a, input int m);
        int r;
        r = 0;
        for (int i = 1; i < m; i++) begin
            if (r == 0 && ((a * i) % m) == 1) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/rns_mrc_digit.sv
// One mixed-radix digit step: d = ((x - y) * K) mod M, with both operands
// reduced first so the subtraction never goes negative.
module rns_mrc_digit #(
    parameter int M  = 8,
    parameter int K  = 1,
    parameter int WX = 3,
    parameter int WY = 4,
    parameter int WO = 3
) (
    input  logic [WX-1:0] x_i,
    input  logic [WY-1:0] y_i,
    output logic [WO-1:0] d_o
);

    localparam logic [31:0] MM = 32'(M);
    localparam logic [31:0] KK = 32'(K);

    logic [31:0] xm;
    logic [31:0] ym;
    logic [31:0] diff;
    logic [31:0] prod;

    assign xm   = 32'(x_i) % MM;
    assign ym   = 32'(y_i) % MM;
    assign diff = (xm + MM - ym) % MM;
    assign prod = (diff * KK) % MM;
    assign d_o  = WO'(prod);

endmodule

// File: rtl/rns_compare_const_mrc.sv
// Converts a 3-channel RNS operand to binary by mixed-radix conversion and
// compares it with a runtime-loadable threshold; one operand in flight.
module rns_compare_const_mrc
    import rns_pkg::*;
#(
    parameter int M1       = 9,
    parameter int M2       = 8,
    parameter int M3       = 7,
    parameter int THR_INIT = 10,
    localparam int W1      = clog2(M1),
    localparam int W2      = clog2(M2),
    localparam int W3      = clog2(M3),
    localparam int W       = clog2(M1 * M2 * M3)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W1-1:0] a1_in,
    input  logic [W2-1:0] a2_in,
    input  logic [W3-1:0] a3_in,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          thr_load,
    input  logic [W-1:0]  thr_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  value_out,
    output logic          res_le_out,
    output logic          res_eq_out,
    output logic          res_gr_out,
    output logic          err_out
);

    localparam int INV12 = mod_inv(M1 % M2, M2);
    localparam int INV13 = mod_inv(M1 % M3, M3);
    localparam int INV23 = mod_inv(M2 % M3, M3);

    if (gcd(M1, M2) != 1 || gcd(M1, M3) != 1 || gcd(M2, M3) != 1 ||
        M1 < 2 || M2 < 2 || M3 < 2) begin : g_bad_moduli
        $fatal(1, "rns_compare_const_mrc: moduli must be >= 2 and pairwise coprime");
    end

    state_e        state_q, state_d;
    logic          rdy_q;
    logic [W-1:0]  thr_q;
    logic [W-1:0]  thr_cap_q;
    logic [W1-1:0] v1_q;
    logic [W2-1:0] a2_q;
    logic [W3-1:0] a3_q;
    logic          err_q;
    logic [W2-1:0] v2_q, v2_d;
    logic [W3-1:0] t_q, t_d;
    logic [W3-1:0] v3_d;
    logic [W-1:0]  value_q;
    logic          le_q, eq_q, gr_q, erro_q;

    logic          accept;
    logic          bad_in;
    logic [31:0]   val32;
    logic          lt, eqv;

    // rdy_q keeps in_ready low until the first edge after reset release.
    assign in_ready = rdy_q && (state_q == IDLE);
    assign accept   = in_valid && in_ready;
    assign bad_in   = (32'(a1_in) >= 32'(M1)) || (32'(a2_in) >= 32'(M2)) ||
                      (32'(a3_in) >= 32'(M3));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = MRC1;
            MRC1:    state_d = MRC2;
            MRC2:    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // MRC1 produces v2 and the first half of v3 (t) in parallel.
    rns_mrc_digit #(.M(M2), .K(INV12), .WX(W2), .WY(W1), .WO(W2)) u_digit_v2 (
        .x_i (a2_q),
        .y_i (v1_q),
        .d_o (v2_d)
    );

    rns_mrc_digit #(.M(M3), .K(INV13), .WX(W3), .WY(W1), .WO(W3)) u_digit_t (
        .x_i (a3_q),
        .y_i (v1_q),
        .d_o (t_d)
    );

    rns_mrc_digit #(.M(M3), .K(INV23), .WX(W3), .WY(W2), .WO(W3)) u_digit_v3 (
        .x_i (t_q),
        .y_i (v2_q),
        .d_o (v3_d)
    );

    assign val32 = 32'(v1_q) + 32'(v2_q) * 32'(M1) + 32'(v3_d) * 32'(M1 * M2);
    assign lt    = val32 <  32'(thr_cap_q);
    assign eqv   = val32 == 32'(thr_cap_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rdy_q     <= 1'b0;
            thr_q     <= W'(THR_INIT);
            thr_cap_q <= '0;
            v1_q      <= '0;
            a2_q      <= '0;
            a3_q      <= '0;
            err_q     <= 1'b0;
            v2_q      <= '0;
            t_q       <= '0;
            value_q   <= '0;
            le_q      <= 1'b0;
            eq_q      <= 1'b0;
            gr_q      <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            if (thr_load) thr_q <= thr_in;
            // The operand captures the pre-load threshold on a shared edge.
            if (accept) begin
                v1_q      <= a1_in;
                a2_q      <= a2_in;
                a3_q      <= a3_in;
                thr_cap_q <= thr_q;
                err_q     <= bad_in;
            end
            if (state_q == MRC1) begin
                v2_q <= v2_d;
                t_q  <= t_d;
            end
            if (state_q == MRC2) begin
                value_q <= err_q ? '0 : W'(val32);
                le_q    <= !err_q && lt;
                eq_q    <= !err_q && eqv;
                gr_q    <= !err_q && !lt && !eqv;
                erro_q  <= err_q;
            end
        end
    end

    assign out_valid  = (state_q == DONE);
    assign value_out  = out_valid ? value_q : '0;
    assign res_le_out = out_valid && le_q;
    assign res_eq_out = out_valid && eq_q;
    assign res_gr_out = out_valid && gr_q;
    assign err_out    = out_valid && erro_q;

endmodule

// File: tb/tb_rns_compare_const_mrc.sv
// Directed bench for rns_compare_const_mrc at default moduli (9, 8, 7).
module tb_rns_compare_const_mrc;

    logic       clk;
    logic       rst_n;
    logic [3:0] a1_in;
    logic [2:0] a2_in;
    logic [2:0] a3_in;
    logic       in_valid;
    logic       in_ready;
    logic       thr_load;
    logic [8:0] thr_in;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] value_out;
    logic       res_le_out;
    logic       res_eq_out;
    logic       res_gr_out;
    logic       err_out;

    int errors = 0;
    int checks = 0;

    rns_compare_const_mrc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a1_in      (a1_in),
        .a2_in      (a2_in),
        .a3_in      (a3_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .thr_load   (thr_load),
        .thr_in     (thr_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .value_out  (value_out),
        .res_le_out (res_le_out),
        .res_eq_out (res_eq_out),
        .res_gr_out (res_gr_out),
        .err_out    (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [3:0] a1, input logic [2:0] a2, input logic [2:0] a3);
        @(negedge clk);
        a1_in = a1; a2_in = a2; a3_in = a3;
        in_valid = 1'b1;
        chk("in_ready_before_accept", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Called #1 after the accept edge: result is visible after the second edge
    // following accept, i.e. first seen high by a sampler at the third edge.
    task automatic wait_result();
        chk("out_valid_lat0", out_valid, 0);
        @(posedge clk); #1;
        chk("out_valid_lat1", out_valid, 0);
        @(posedge clk); #1;
        chk("out_valid_lat2", out_valid, 1);
    endtask

    task automatic check_res(input string tag, input logic [8:0] v, input logic le,
                             input logic eq, input logic gr, input logic er);
        chk({tag, "_value"}, value_out, v);
        chk({tag, "_le"}, res_le_out, le);
        chk({tag, "_eq"}, res_eq_out, eq);
        chk({tag, "_gr"}, res_gr_out, gr);
        chk({tag, "_err"}, err_out, er);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("out_valid_after_handshake", out_valid, 0);
        chk("in_ready_after_handshake", in_ready, 1);
    endtask

    task automatic load_thr(input logic [8:0] v);
        @(negedge clk);
        thr_load = 1'b1;
        thr_in = v;
        @(posedge clk);
        #1 thr_load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a1_in = '0; a2_in = '0; a3_in = '0;
        in_valid = 1'b0; thr_load = 1'b0; thr_in = '0; out_ready = 1'b0;

        #3;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_value", value_out, 0);
        #14 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_release", in_ready, 1);

        // 10 = 1 + 1*9 + 0*72
        send(4'd1, 3'd2, 3'd3);
        wait_result();
        check_res("x10_thr10", 9'd10, 0, 1, 0, 0);
        release_out();

        send(4'd0, 3'd0, 3'd0);
        wait_result();
        check_res("x0", 9'd0, 1, 0, 0, 0);
        release_out();

        // 503 = 8 + 7*9 + 6*72
        send(4'd8, 3'd7, 3'd6);
        wait_result();
        check_res("x503", 9'd503, 0, 0, 1, 0);
        release_out();

        load_thr(9'd503);
        send(4'd8, 3'd7, 3'd6);
        wait_result();
        check_res("x503_thr503", 9'd503, 0, 1, 0, 0);
        release_out();

        // Load on the accept edge: operand must see the old threshold (10).
        load_thr(9'd10);
        @(negedge clk);
        a1_in = 4'd1; a2_in = 3'd2; a3_in = 3'd3;
        in_valid = 1'b1; thr_load = 1'b1; thr_in = 9'd0;
        @(posedge clk);
        #1 begin in_valid = 1'b0; thr_load = 1'b0; end
        wait_result();
        check_res("same_edge_old_thr", 9'd10, 0, 1, 0, 0);
        release_out();

        send(4'd1, 3'd2, 3'd3);
        wait_result();
        check_res("x10_thr0", 9'd10, 0, 0, 1, 0);
        release_out();

        // Threshold beyond the dynamic range: every valid operand is below it.
        load_thr(9'd511);
        send(4'd8, 3'd7, 3'd6);
        wait_result();
        check_res("x503_thr511", 9'd503, 1, 0, 0, 0);
        release_out();

        send(4'd9, 3'd0, 3'd0);
        wait_result();
        check_res("a1_out_of_range", 9'd0, 0, 0, 0, 1);
        release_out();

        // Back-pressure: result must hold while out_ready stays low.
        send(4'd1, 3'd2, 3'd3);
        wait_result();
        check_res("stall_start", 9'd10, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_out_valid", out_valid, 1);
            chk("stall_value", value_out, 10);
            chk("stall_le", res_le_out, 1);
            chk("stall_in_ready", in_ready, 0);
        end
        release_out();
        send(4'd0, 3'd0, 3'd0);
        wait_result();
        check_res("after_stall", 9'd0, 1, 0, 0, 0);
        release_out();

        // Reset during MRC1 discards the operand and restores THR_INIT.
        send(4'd8, 3'd7, 3'd6);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_out_valid", out_valid, 0);
        end
        send(4'd1, 3'd2, 3'd3);
        wait_result();
        check_res("post_reset_thr10", 9'd10, 0, 1, 0, 0);
        release_out();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL timeout: observed no completion expected finish before 50000");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
